trap_ctrl: RTL and testbench
============================

# trap_ctrl

Exception/trap controller feeding the CSR block: arbitrates exception requests from the ID, EX and MEM pipeline stages and produces the one-cycle `exception_sig`, `exception_pc` and `exception_cause` write strobe that the CSR block latches into EPC/CAUSE. It also drives the pipeline flush and the fetch redirect to the trap vector. On exception return, it asserts the CSR read enable `CSR_inst_on`, samples the returned `epc`, and redirects fetch back to it.

## Interface
Parameters:
- `TRAP_VECTOR`, 32'h0000_1000, fetch address of the trap handler
- `FLUSH_CYCLES`, 3, cycles `flush` is held for an exception (legal range 1..15)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `id_illegal`  in  1  illegal instruction detected in ID
- `id_pc`  in  32  PC of the ID instruction
- `ex_overflow`  in  1  arithmetic overflow in EX
- `ex_pc`  in  32  PC of the EX instruction
- `mem_misalign`  in  1  misaligned load/store in MEM
- `mem_fault`  in  1  memory access fault in MEM
- `mem_pc`  in  32  PC of the MEM instruction
- `eret_req`  in  1  exception-return instruction at MEM (commit point)
- `csr_epc`  in  32  `epc` output of the CSR block; valid only while `CSR_inst_on`=1
- `exception_sig`  out  1  one-cycle CSR write strobe
- `exception_pc`  out  32  faulting PC to the CSR
- `exception_cause`  out  5  cause code to the CSR
- `CSR_inst_on`  out  1  CSR read enable
- `flush`  out  1  kill the IF/ID/EX pipeline registers
- `redirect_valid`  out  1  one-cycle fetch redirect
- `redirect_pc`  out  32  redirect target
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- Cause codes: MISALIGN=5'd4, MEM_FAULT=5'd5, ILLEGAL=5'd2, OVERFLOW=5'd12.
- Priority in IDLE (oldest instruction wins):
  - `mem_misalign` > `mem_fault` > `eret_req` > `ex_overflow` > `id_illegal`.
  - The lower-priority requests in the same cycle are dropped. The pipeline re-raises them after flush if they are still relevant.
- States:
  - IDLE: on a winning exception, register the PC and cause, set `exception_sig`=1 and `flush`=1, load the counter with FLUSH_CYCLES-1, and go to FLUSH. On a winning `eret_req`, set `CSR_inst_on`=1 and `flush`=1, and go to ERET_READ.
  - FLUSH: `flush`=1. Decrement the counter. When the counter is 0, go to REDIRECT.
  - REDIRECT: `redirect_valid`=1 and `redirect_pc`=TRAP_VECTOR for one cycle, then go to IDLE.
  - ERET_READ: capture `csr_epc` at the clock edge, then go to ERET_REDIR.
  - ERET_REDIR: `redirect_valid`=1 and `redirect_pc`=the captured epc for one cycle, then go to IDLE.
- All exception and `eret_req` inputs are ignored outside IDLE.
- `exception_pc` and `exception_cause` hold their last values after the strobe. Only `exception_sig` qualifies them.
- `exception_cause` is the 5-bit code. The CSR zero-extends it.

## Timing
- All outputs are registered. The combinational CSR read path is the only input used outside the registered logic.
- Exception sampled at edge T:
  - `exception_sig`=1 in cycle T+1 only.
  - `flush`=1 in cycles T+1 .. T+FLUSH_CYCLES.
  - `redirect_valid`=1 in cycle T+FLUSH_CYCLES+1.
  - IDLE again in T+FLUSH_CYCLES+2.
- The CSR latches EPC/CAUSE at the edge ending T+1.
- `eret_req` sampled at edge T:
  - `CSR_inst_on`=1 and `flush`=1 in T+1.
  - `csr_epc` sampled at the edge ending T+1.
  - `redirect_valid`=1 in T+2.
  - IDLE in T+3.
- A new exception may be accepted in the same cycle IDLE is re-entered.
- Reset values: state=IDLE, counter=0. Every output is 0, including `exception_pc`, `exception_cause`, `redirect_pc` and `busy`.
- Reset mid-operation returns to IDLE at the next edge and discards the pending trap or return. No redirect is issued.

## Structure
- Package `trap_pkg`:
  - cause-code localparams
  - state encoding (IDLE, FLUSH, REDIRECT, ERET_READ, ERET_REDIR)
  - counter width (4 bits)
- Sub-module `trap_prio_enc`: combinational. Takes the five request bits and three PCs. Outputs `hit`, `is_eret`, the selected PC and the cause.
- The top level holds the FSM, counter and output registers.

## Test plan
- `ex_overflow`=1 with `ex_pc`=0x200 for one cycle:
  - `exception_sig` pulses once with pc=0x200 and cause=12.
  - `flush` is high for 3 cycles.
  - `redirect_valid` then pulses with pc=0x1000.
- Same cycle `mem_fault` (pc=0x300) + `ex_overflow` (0x304) + `id_illegal` (0x308) -> only cause=5 with pc=0x300 is reported.
- `eret_req` with CSR `epc`=0x1234 -> `CSR_inst_on` high for 1 cycle, then `redirect_pc`=0x1234 with `redirect_valid` 2 cycles after the request.
- `mem_misalign` and `eret_req` together -> exception path is taken with cause=4. `CSR_inst_on` stays 0.
- `id_illegal` asserted during FLUSH -> ignored. There is no second `exception_sig`.
- `reset` asserted in the 2nd FLUSH cycle -> all outputs 0 at the next edge, no redirect, and the next exception is handled normally.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared cause codes, FSM encoding and counter width
// for the trap controller slice.
package trap_pkg;

  localparam logic [4:0] CAUSE_ILLEGAL   = 5'd2;
  localparam logic [4:0] CAUSE_MISALIGN  = 5'd4;
  localparam logic [4:0] CAUSE_MEM_FAULT = 5'd5;
  localparam logic [4:0] CAUSE_OVERFLOW  = 5'd12;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT,
    ST_ERET_READ,
    ST_ERET_REDIR
  } trap_state_t;

endpackage

// File: rtl/trap_prio_enc.sv
// Picks the oldest pending trap request; the MEM stage
// outranks EX, which outranks ID.
module trap_prio_enc
  import trap_pkg::*;
(
  input  logic        id_illegal,
  input  logic        ex_overflow,
  input  logic        mem_misalign,
  input  logic        mem_fault,
  input  logic        eret_req,
  input  logic [31:0] id_pc,
  input  logic [31:0] ex_pc,
  input  logic [31:0] mem_pc,
  output logic        hit,
  output logic        is_eret,
  output logic [31:0] sel_pc,
  output logic [4:0]  sel_cause
);

  always_comb begin
    hit       = 1'b0;
    is_eret   = 1'b0;
    sel_pc    = '0;
    sel_cause = '0;
    priority case (1'b1)
      mem_misalign: begin
        hit       = 1'b1;
        sel_pc    = mem_pc;
        sel_cause = CAUSE_MISALIGN;
      end
      mem_fault: begin
        hit       = 1'b1;
        sel_pc    = mem_pc;
        sel_cause = CAUSE_MEM_FAULT;
      end
      eret_req: begin
        hit     = 1'b1;
        is_eret = 1'b1;
        sel_pc  = mem_pc;
      end
      ex_overflow: begin
        hit       = 1'b1;
        sel_pc    = ex_pc;
        sel_cause = CAUSE_OVERFLOW;
      end
      id_illegal: begin
        hit       = 1'b1;
        sel_pc    = id_pc;
        sel_cause = CAUSE_ILLEGAL;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/return sequencer: CSR write strobe, pipeline flush
// and fetch redirect to the handler or back to EPC.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_1000,
  parameter int          FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_illegal,
  input  logic [31:0] id_pc,
  input  logic        ex_overflow,
  input  logic [31:0] ex_pc,
  input  logic        mem_misalign,
  input  logic        mem_fault,
  input  logic [31:0] mem_pc,
  input  logic        eret_req,
  input  logic [31:0] csr_epc,
  output logic        exception_sig,
  output logic [31:0] exception_pc,
  output logic [4:0]  exception_cause,
  output logic        CSR_inst_on,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  trap_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             sig_n;

  logic        hit;
  logic        is_eret;
  logic [31:0] sel_pc;
  logic [4:0]  sel_cause;

  trap_prio_enc u_prio (
    .id_illegal   (id_illegal),
    .ex_overflow  (ex_overflow),
    .mem_misalign (mem_misalign),
    .mem_fault    (mem_fault),
    .eret_req     (eret_req),
    .id_pc        (id_pc),
    .ex_pc        (ex_pc),
    .mem_pc       (mem_pc),
    .hit          (hit),
    .is_eret      (is_eret),
    .sel_pc       (sel_pc),
    .sel_cause    (sel_cause)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sig_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (hit && is_eret) begin
          state_n = ST_ERET_READ;
        end else if (hit) begin
          state_n = ST_FLUSH;
          cnt_n   = CNT_W'(FLUSH_CYCLES - 1);
          sig_n   = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (cnt == '0) state_n = ST_REDIRECT;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      ST_REDIRECT:   state_n = ST_IDLE;
      ST_ERET_READ:  state_n = ST_ERET_REDIR;
      ST_ERET_REDIR: state_n = ST_IDLE;
      default:       state_n = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line
  // up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      exception_sig   <= 1'b0;
      exception_pc    <= '0;
      exception_cause <= '0;
      CSR_inst_on     <= 1'b0;
      flush           <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= '0;
      busy            <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      exception_sig  <= sig_n;
      CSR_inst_on    <= (state_n == ST_ERET_READ);
      flush          <= (state_n == ST_FLUSH) ||
                        (state_n == ST_ERET_READ);
      redirect_valid <= (state_n == ST_REDIRECT) ||
                        (state_n == ST_ERET_REDIR);
      busy           <= (state_n != ST_IDLE);
      if (sig_n) begin
        exception_pc    <= sel_pc;
        exception_cause <= sel_cause;
      end
      if (state_n == ST_REDIRECT)
        redirect_pc <= TRAP_VECTOR;
      else if (state_n == ST_ERET_REDIR)
        redirect_pc <= csr_epc;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized bench for trap_ctrl against a timeline model
// of each accepted trap or return.
module tb_trap_ctrl;

  localparam logic [31:0] TV = 32'h0000_1000;
  localparam int          FC = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_illegal, ex_overflow;
  logic        mem_misalign, mem_fault, eret_req;
  logic [31:0] id_pc, ex_pc, mem_pc, csr_epc;
  logic        exception_sig, CSR_inst_on, flush;
  logic        redirect_valid, busy;
  logic [31:0] exception_pc, redirect_pc;
  logic [4:0]  exception_cause;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // model: one active event started at edge t0
  bit          active = 0;
  bit          ev_eret = 0;
  int          t0 = 0;
  logic [31:0] ev_pc, ev_epc;
  logic [4:0]  ev_cause;
  logic [31:0] h_pc = '0, h_rpc = '0;
  logic [4:0]  h_cause = '0;

  always #5 clk = ~clk;

  trap_ctrl #(.TRAP_VECTOR(TV), .FLUSH_CYCLES(FC)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_illegal      (id_illegal),
    .id_pc           (id_pc),
    .ex_overflow     (ex_overflow),
    .ex_pc           (ex_pc),
    .mem_misalign    (mem_misalign),
    .mem_fault       (mem_fault),
    .mem_pc          (mem_pc),
    .eret_req        (eret_req),
    .csr_epc         (csr_epc),
    .exception_sig   (exception_sig),
    .exception_pc    (exception_pc),
    .exception_cause (exception_cause),
    .CSR_inst_on     (CSR_inst_on),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .busy            (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic int ev_len();
    return ev_eret ? 3 : FC + 2;
  endfunction

  task automatic start(input bit er,
                       input logic [31:0] pc,
                       input logic [4:0] c);
    active   = 1;
    ev_eret  = er;
    t0       = cyc - 1;
    ev_pc    = pc;
    ev_cause = c;
  endtask

  // Apply the edge just taken, using inputs it sampled.
  task automatic model_edge();
    if (reset) begin
      active  = 0;
      h_pc    = '0;
      h_cause = '0;
      h_rpc   = '0;
    end else begin
      if (active && ev_eret && (cyc - 1 == t0 + 1))
        ev_epc = csr_epc;
      if (!active || (cyc - 1 >= t0 + ev_len())) begin
        active = 0;
        if (mem_misalign)     start(0, mem_pc, 5'd4);
        else if (mem_fault)   start(0, mem_pc, 5'd5);
        else if (eret_req)    start(1, mem_pc, 5'd0);
        else if (ex_overflow) start(0, ex_pc, 5'd12);
        else if (id_illegal)  start(0, id_pc, 5'd2);
      end
    end
  endtask

  task automatic model_check();
    int d;
    bit e_sig, e_on, e_fl, e_rv, e_bz;
    d = cyc - t0;
    e_sig = 0; e_on = 0; e_fl = 0; e_rv = 0; e_bz = 0;
    if (active && !ev_eret) begin
      e_sig = (d == 1);
      e_fl  = (d >= 1 && d <= FC);
      e_rv  = (d == FC + 1);
      e_bz  = (d >= 1 && d <= FC + 1);
      if (e_sig) begin
        h_pc    = ev_pc;
        h_cause = ev_cause;
      end
      if (e_rv) h_rpc = TV;
    end else if (active) begin
      e_on = (d == 1);
      e_fl = (d == 1);
      e_rv = (d == 2);
      e_bz = (d >= 1 && d <= 2);
      if (e_rv) h_rpc = ev_epc;
    end
    check("exception_sig", 32'(exception_sig), 32'(e_sig));
    check("exception_pc", exception_pc, h_pc);
    check("exception_cause", 32'(exception_cause),
          32'(h_cause));
    check("CSR_inst_on", 32'(CSR_inst_on), 32'(e_on));
    check("flush", 32'(flush), 32'(e_fl));
    check("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    check("redirect_pc", redirect_pc, h_rpc);
    check("busy", 32'(busy), 32'(e_bz));
  endtask

  task automatic step(input logic r,
                      input logic mis, flt, er, ovf, ill,
                      input logic [31:0] mp, ep, ip, ce);
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    model_check();
    reset        = r;
    mem_misalign = mis;
    mem_fault    = flt;
    eret_req     = er;
    ex_overflow  = ovf;
    id_illegal   = ill;
    mem_pc       = mp;
    ex_pc        = ep;
    id_pc        = ip;
    csr_epc      = ce;
  endtask

  task automatic idle(input int n, input logic [31:0] ce);
    repeat (n) step(0, 0, 0, 0, 0, 0, $urandom, $urandom,
                    $urandom, ce);
  endtask

  initial begin
    reset = 1; id_illegal = 0; ex_overflow = 0;
    mem_misalign = 0; mem_fault = 0; eret_req = 0;
    id_pc = 0; ex_pc = 0; mem_pc = 0; csr_epc = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 32'h0);
    // overflow at 0x200
    step(0, 0, 0, 0, 1, 0, 32'h0, 32'h200, 32'h0, 32'h0);
    idle(7, 32'h0);
    // three-way collision, MEM fault wins
    step(0, 0, 1, 0, 1, 1, 32'h300, 32'h304, 32'h308, 0);
    idle(7, 32'h0);
    // exception return to 0x1234
    step(0, 0, 0, 1, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0);
    idle(4, 32'h1234);
    // misalign beats eret
    step(0, 1, 0, 1, 0, 0, 32'h500, 32'h0, 32'h0, 32'h0);
    idle(7, 32'h9999);
    // illegal during flush is ignored
    step(0, 0, 0, 0, 1, 0, 32'h0, 32'h600, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h700, 32'h0);
    idle(7, 32'h0);
    // reset in the 2nd flush cycle, then a normal trap
    step(0, 0, 0, 0, 1, 0, 32'h0, 32'h800, 32'h0, 32'h0);
    idle(1, 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    idle(6, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h900, 32'h0);
    idle(7, 32'h0);
    // back-to-back: request held while busy
    repeat (12)
      step(0, 0, 0, $urandom_range(0, 1) == 1, 1, 0,
           $urandom, $urandom, $urandom, $urandom);
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 90) == 0,
           ($urandom % 12) == 0, ($urandom % 12) == 0,
           ($urandom % 8) == 0, ($urandom % 8) == 0,
           ($urandom % 8) == 0,
           $urandom, $urandom, $urandom, $urandom);
    end
    idle(8, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
